// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//   Shares the single UDP transmit path of the eth core between NUM_REQ
//   requesters. It grants the send buffer round-robin. On a valid commit it
//   latches the owner's header fields and fires a one-cycle send trigger.
//   It then waits for completion or timeout and inserts an inter-frame gap
//   before the next arbitration.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req[k]              level request for the send path
//   i_commit[k]           pulse: buffer filled, send now
//   i_abort[k]            pulse: release grant without sending
//   i_dest_ip/i_src_port/i_dest_port/i_length
//                         per-requester header slices (slice k at k*width)
//   i_tx_done             pulse from eth core: frame sent
//   o_grant               one-hot registered grant (drives send-buffer write mux)
//   o_send_*              header registers to eth core
//   o_send_trigger        one-cycle start pulse to eth core
//   o_done/o_err/o_timeout  per-requester completion / bad-length / timeout pulses
//   o_busy                high whenever the arbiter is not IDLE
module eth_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int BUF_SIZE       = 1024,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_commit,
  input  logic [NUM_REQ-1:0]     i_abort,
  input  logic [NUM_REQ*32-1:0]  i_dest_ip,
  input  logic [NUM_REQ*16-1:0]  i_src_port,
  input  logic [NUM_REQ*16-1:0]  i_dest_port,
  input  logic [NUM_REQ*16-1:0]  i_length,
  input  logic                   i_tx_done,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [31:0]            o_send_dest_ip,
  output logic [15:0]            o_send_src_port,
  output logic [15:0]            o_send_dest_port,
  output logic [15:0]            o_send_length,
  output logic                   o_send_trigger,
  output logic [NUM_REQ-1:0]     o_done,
  output logic [NUM_REQ-1:0]     o_err,
  output logic [NUM_REQ-1:0]     o_timeout,
  output logic                   o_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [16:0]   BUF_BYTES = 17'(BUF_SIZE / 8);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_TRIGGER, S_WAIT_DONE, S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 trigger_q, trigger_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [NUM_REQ-1:0]   timeout_q, timeout_d;
  logic [31:0]          dest_ip_q, dest_ip_d;
  logic [15:0]          src_port_q, src_port_d;
  logic [15:0]          dest_port_q, dest_port_d;
  logic [15:0]          length_q, length_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;

  // Arbiter and owner-slice selection.
  logic [PW-1:0]        sel_idx;
  logic                 sel_found;
  logic [NUM_REQ-1:0]   own_oh;
  logic [31:0]          own_ip;
  logic [15:0]          own_sp, own_dp, own_len;

  always_comb begin
    int cand;
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cand      = 0;
    sel_idx   = '0;
    sel_found = 1'b0;
    own_oh    = '0;
    own_ip    = '0;
    own_sp    = '0;
    own_dp    = '0;
    own_len   = '0;
    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!sel_found && i_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(cand);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == PW'(k)) begin
        own_oh[k] = 1'b1;
        own_ip    = i_dest_ip[k*32 +: 32];
        own_sp    = i_src_port[k*16 +: 16];
        own_dp    = i_dest_port[k*16 +: 16];
        own_len   = i_length[k*16 +: 16];
      end
    end
  end

  // State register. Header registers are reset too, so every output is 0
  // out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      trigger_q   <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      timeout_q   <= '0;
      dest_ip_q   <= '0;
      src_port_q  <= '0;
      dest_port_q <= '0;
      length_q    <= '0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      trigger_q   <= trigger_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      dest_ip_q   <= dest_ip_d;
      src_port_q  <= src_port_d;
      dest_port_q <= dest_port_d;
      length_q    <= length_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    trigger_d   = 1'b0;
    done_d      = '0;
    err_d       = '0;
    timeout_d   = '0;
    dest_ip_d   = dest_ip_q;
    src_port_d  = src_port_q;
    dest_port_d = dest_port_q;
    length_d    = length_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          grant_d = '0;
          grant_d[sel_idx] = 1'b1;
          ptr_d   = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Only the owner's strobes count; abort beats a same-cycle commit.
        if (|(i_abort & own_oh)) begin
          grant_d = '0;
          state_d = S_IDLE;
        end else if (|(i_commit & own_oh)) begin
          grant_d = '0;
          if (own_len == 16'd0 || {1'b0, own_len} > BUF_BYTES) begin
            err_d   = own_oh;
            state_d = S_IDLE;
          end else begin
            dest_ip_d   = own_ip;
            src_port_d  = own_sp;
            dest_port_d = own_dp;
            length_d    = own_len;
            trigger_d   = 1'b1;
            state_d     = S_TRIGGER;
          end
        end
      end
      S_TRIGGER: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_tx_done || to_cnt_q == TO_LAST) begin
          // Done wins over a coincident timeout.
          if (i_tx_done) done_d    = own_oh;
          else           timeout_d = own_oh;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d   = S_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_grant          = grant_q;
    o_send_trigger   = trigger_q;
    o_done           = done_q;
    o_err            = err_q;
    o_timeout        = timeout_q;
    o_send_dest_ip   = dest_ip_q;
    o_send_src_port  = src_port_q;
    o_send_dest_port = dest_port_q;
    o_send_length    = length_q;
    o_busy           = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Testbench for eth_tx_arbiter (NUM_REQ=2, BUF_SIZE=1024, TIMEOUT=100, GAP=16).
// Pulse outputs (trigger/done/err/timeout) are matched against a scoreboard
// queue filled when the stimulus that should cause them is driven; each
// scenario task also checks grant, busy, header and timing values inline.
module tb_eth_tx_arbiter;
  localparam int N  = 2;
  localparam int BS = 1024;
  localparam int TO = 100;
  localparam int GP = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0, commit = '0, abrt = '0;
  logic [N*32-1:0] dip = '0;
  logic [N*16-1:0] sp = '0, dp = '0, len = '0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    o_grant, o_done, o_err, o_timeout;
  logic [31:0]     o_ip;
  logic [15:0]     o_sp, o_dp, o_len;
  logic            o_trig, o_busy;

  eth_tx_arbiter #(.NUM_REQ(N), .BUF_SIZE(BS), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_commit(commit), .i_abort(abrt),
    .i_dest_ip(dip), .i_src_port(sp), .i_dest_port(dp), .i_length(len),
    .i_tx_done(tx_done), .o_grant(o_grant), .o_send_dest_ip(o_ip),
    .o_send_src_port(o_sp), .o_send_dest_port(o_dp), .o_send_length(o_len),
    .o_send_trigger(o_trig), .o_done(o_done), .o_err(o_err),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef enum int {EV_TRIG, EV_DONE, EV_ERR, EV_TMO} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [N-1:0] who;
    logic [31:0] ip;
    logic [15:0] sp, dp, len;
  } ev_t;
  ev_t exp_q[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_ev(input ev_kind_e kind, input logic [N-1:0] who,
                         input logic [31:0] ip, input logic [15:0] s,
                         input logic [15:0] d, input logic [15:0] l);
    ev_t e;
    e.kind = kind; e.who = who; e.ip = ip; e.sp = s; e.dp = d; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic set_hdr(input int k, input logic [31:0] ip, input logic [15:0] s,
                         input logic [15:0] d, input logic [15:0] l);
    dip[k*32 +: 32] = ip;
    sp[k*16 +: 16]  = s;
    dp[k*16 +: 16]  = d;
    len[k*16 +: 16] = l;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; commit = '0; abrt = '0; tx_done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: any pulse output pops one expected event.
  always @(negedge clk) begin
    ev_t e;
    ev_kind_e k;
    logic [N-1:0] w;
    logic hit;
    k = EV_TRIG; w = '0; hit = 1'b1;
    if (o_trig)          k = EV_TRIG;
    else if (|o_done)    begin k = EV_DONE; w = o_done;    end
    else if (|o_err)     begin k = EV_ERR;  w = o_err;     end
    else if (|o_timeout) begin k = EV_TMO;  w = o_timeout; end
    else hit = 1'b0;
    if (hit) begin
      total++;
      if ($countones({o_trig, o_done, o_err, o_timeout}) != 1) begin
        bad++;
        $display("FAIL sb_multi_pulse: got trig=%b done=%b err=%b tmo=%b, expected a single pulse",
                 o_trig, o_done, o_err, o_timeout);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got event kind=%0d who=%b, expected none", k, w);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== k || (k != EV_TRIG && e.who !== w) ||
            (k == EV_TRIG && {o_ip, o_sp, o_dp, o_len} !== {e.ip, e.sp, e.dp, e.len})) begin
          bad++;
          $display("FAIL sb_event: got kind=%0d who=%b hdr=%h/%0d/%0d/%0d, expected kind=%0d who=%b hdr=%h/%0d/%0d/%0d",
                   k, w, o_ip, o_sp, o_dp, o_len, e.kind, e.who, e.ip, e.sp, e.dp, e.len);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 300) begin step(); n++; end
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", o_busy, n);
    end
  endtask

  task automatic finish_frame(input int k);
    logic [N-1:0] oh;
    oh = '0; oh[k] = 1'b1;
    repeat (3) step();
    tx_done = 1'b1;
    push_ev(EV_DONE, oh, '0, '0, '0, '0);
    step();
    tx_done = 1'b0;
    total++;
    if (o_done !== oh) begin
      bad++; $display("FAIL frame_done: got %b, expected %b", o_done, oh);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if ({o_grant, o_trig, o_done, o_err, o_timeout, o_busy, o_ip, o_sp, o_dp, o_len} !== '0) begin
      bad++; $display("FAIL reset_outputs: got grant=%b busy=%b hdr=%h, expected all 0",
                      o_grant, o_busy, o_ip);
    end
    rst = 1'b0;
    step();
    total++;
    if (o_busy !== 1'b0 || o_grant !== '0) begin
      bad++; $display("FAIL reset_idle: got busy=%b grant=%b, expected 0/00", o_busy, o_grant);
    end
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    set_hdr(0, 32'h0A000002, 16'd1234, 16'd5678, 16'd64);
    req = 2'b01;
    step();
    total++;
    if (o_grant !== 2'b01 || o_busy !== 1'b1) begin
      bad++; $display("FAIL single_grant: got grant=%b busy=%b, expected 01/1", o_grant, o_busy);
    end
    commit = 2'b01;
    push_ev(EV_TRIG, '0, 32'h0A000002, 16'd1234, 16'd5678, 16'd64);
    step();
    commit = '0; req = '0;
    total++;
    if (o_trig !== 1'b1 || o_grant !== '0 || {o_ip, o_sp, o_dp, o_len} !==
        {32'h0A000002, 16'd1234, 16'd5678, 16'd64}) begin
      bad++; $display("FAIL single_trigger: got trig=%b grant=%b hdr=%h/%0d/%0d/%0d, expected 1/00/0a000002/1234/5678/64",
                      o_trig, o_grant, o_ip, o_sp, o_dp, o_len);
    end
    step();
    total++;
    if (o_trig !== 1'b0) begin
      bad++; $display("FAIL single_trigger_width: got trig=%b, expected 0", o_trig);
    end
    repeat (9) step();
    tx_done = 1'b1;
    push_ev(EV_DONE, 2'b01, '0, '0, '0, '0);
    step();
    tx_done = 1'b0;
    total++;
    if (o_done !== 2'b01 || o_busy !== 1'b1) begin
      bad++; $display("FAIL single_done: got done=%b busy=%b, expected 01/1", o_done, o_busy);
    end
    n = 0;
    while (o_busy && n < 100) begin step(); n++; end
    total++;
    if (n != GP) begin
      bad++; $display("FAIL single_gap: got %0d gap cycles, expected %0d", n, GP);
    end
  endtask

  task automatic test_round_robin();
    int n, k;
    logic [N-1:0] oh;
    apply_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      k = i % 2;
      oh = '0; oh[k] = 1'b1;
      n = 0;
      while (o_grant == '0 && n < 5) begin step(); n++; end
      total++;
      if (o_grant !== oh) begin
        bad++; $display("FAIL rr_grant_%0d: got %b, expected %b", i, o_grant, oh);
      end
      set_hdr(k, 32'hC0000000 + 32'(i), 16'(100 + i), 16'(200 + i), 16'(20 + i));
      commit = oh;
      push_ev(EV_TRIG, '0, 32'hC0000000 + 32'(i), 16'(100 + i), 16'(200 + i), 16'(20 + i));
      step();
      commit = '0;
      step();
      finish_frame(k);
    end
    req = '0;
  endtask

  task automatic test_bad_length();
    apply_reset();
    set_hdr(0, 32'hC0A80001, 16'd100, 16'd200, 16'd128);
    req = 2'b01;
    step();
    commit = 2'b01;
    push_ev(EV_TRIG, '0, 32'hC0A80001, 16'd100, 16'd200, 16'd128);
    step();
    commit = '0; req = '0;
    total++;
    if (o_trig !== 1'b1) begin
      bad++; $display("FAIL len_max_trigger: got trig=%b, expected 1", o_trig);
    end
    step();
    finish_frame(0);
    for (int i = 0; i < 2; i++) begin
      set_hdr(1, 32'h11111111, 16'd1, 16'd2, (i == 0) ? 16'd0 : 16'd129);
      req = 2'b10;
      step();
      total++;
      if (o_grant !== 2'b10) begin
        bad++; $display("FAIL badlen_grant_%0d: got %b, expected 10", i, o_grant);
      end
      commit = 2'b10;
      push_ev(EV_ERR, 2'b10, '0, '0, '0, '0);
      step();
      commit = '0; req = '0;
      total++;
      if (o_err !== 2'b10 || o_trig !== 1'b0 || o_grant !== '0 ||
          {o_ip, o_sp, o_dp, o_len} !== {32'hC0A80001, 16'd100, 16'd200, 16'd128}) begin
        bad++; $display("FAIL badlen_err_%0d: got err=%b trig=%b grant=%b hdr=%h/%0d/%0d/%0d, expected 10/0/00/c0a80001/100/200/128",
                        i, o_err, o_trig, o_grant, o_ip, o_sp, o_dp, o_len);
      end
      step();
      total++;
      if (o_busy !== 1'b0) begin
        bad++; $display("FAIL badlen_idle_%0d: got busy=%b, expected 0", i, o_busy);
      end
    end
  endtask

  task automatic test_abort();
    apply_reset();
    set_hdr(0, 32'h0A0A0A0A, 16'd7, 16'd8, 16'd10);
    set_hdr(1, 32'h0B0B0B0B, 16'd9, 16'd10, 16'd10);
    req = 2'b01;
    step();
    req = '0;
    step();
    total++;
    if (o_grant !== 2'b01) begin
      bad++; $display("FAIL abort_hold: got grant=%b, expected 01", o_grant);
    end
    commit = 2'b01; abrt = 2'b01;
    step();
    commit = '0; abrt = '0;
    total++;
    if (o_grant !== '0 || o_trig !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_race: got grant=%b trig=%b busy=%b, expected 00/0/0",
                      o_grant, o_trig, o_busy);
    end
    req = 2'b01;
    step();
    commit = 2'b10;
    step();
    commit = '0; abrt = 2'b10;
    total++;
    if (o_grant !== 2'b01 || o_trig !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL foreign_commit: got grant=%b trig=%b busy=%b, expected 01/0/1",
                      o_grant, o_trig, o_busy);
    end
    step();
    abrt = 2'b01; req = '0;
    total++;
    if (o_grant !== 2'b01) begin
      bad++; $display("FAIL foreign_abort: got grant=%b, expected 01", o_grant);
    end
    step();
    abrt = '0;
    tx_done = 1'b1;
    total++;
    if (o_grant !== '0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL abort_release: got grant=%b busy=%b, expected 00/0", o_grant, o_busy);
    end
    step();
    tx_done = 1'b0;
    step();
    total++;
    if (o_done !== '0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL idle_tx_done: got done=%b busy=%b, expected 00/0", o_done, o_busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    set_hdr(0, 32'h0A000099, 16'd11, 16'd22, 16'd50);
    for (int pass = 0; pass < 2; pass++) begin
      req = 2'b01;
      step();
      commit = 2'b01;
      push_ev(EV_TRIG, '0, 32'h0A000099, 16'd11, 16'd22, 16'd50);
      step();
      commit = '0; req = '0;
      step();
      if (pass == 0) begin
        push_ev(EV_TMO, 2'b01, '0, '0, '0, '0);
        n = 0;
        while (o_timeout == '0 && n < 200) begin step(); n++; end
        total++;
        if (n != TO || o_done !== '0) begin
          bad++; $display("FAIL timeout_latency: got %0d cycles done=%b, expected %0d/00", n, o_done, TO);
        end
      end else begin
        repeat (TO - 1) step();
        tx_done = 1'b1;
        push_ev(EV_DONE, 2'b01, '0, '0, '0, '0);
        step();
        tx_done = 1'b0;
        total++;
        if (o_done !== 2'b01 || o_timeout !== '0) begin
          bad++; $display("FAIL done_vs_timeout: got done=%b tmo=%b, expected 01/00", o_done, o_timeout);
        end
      end
      wait_idle();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_hdr(0, 32'h0A000003, 16'd33, 16'd44, 16'd60);
    req = 2'b01;
    step();
    commit = 2'b01;
    push_ev(EV_TRIG, '0, 32'h0A000003, 16'd33, 16'd44, 16'd60);
    step();
    commit = '0; req = '0;
    repeat (6) step();
    rst = 1'b1;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    total++;
    if ({o_grant, o_trig, o_done, o_err, o_timeout, o_busy, o_ip, o_sp, o_dp, o_len} !== '0) begin
      bad++; $display("FAIL reset_mid: got grant=%b done=%b busy=%b hdr=%h, expected all 0",
                      o_grant, o_done, o_busy, o_ip);
    end
    rst = 1'b0;
    req = 2'b11;
    step();
    total++;
    if (o_grant !== 2'b01) begin
      bad++; $display("FAIL reset_ptr: got grant=%b, expected 01", o_grant);
    end
    abrt = 2'b01; req = '0;
    step();
    abrt = '0;
    repeat (3) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bad_length();
    test_abort();
    test_timeout();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending events, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet UDP transmit path (send buffer, send header registers, send trigger) between NUM_REQ hardware or software requesters.
- Grants ownership of the send buffer round-robin and captures the granted requester's header fields on commit.
- Issues a one-cycle send trigger to the eth core, then waits for transmit completion, with a timeout and an inter-frame gap.
- Sits between the MMIO front end and other requesters (e.g. ARP/echo responders) and the eth core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- BUF_SIZE, 1024, send buffer size in bits; payload limit BUF_BYTES = BUF_SIZE/8.
- TIMEOUT_CYCLES, 1000000, maximum cycles spent waiting for i_tx_done.
- GAP_CYCLES, 16, idle cycles inserted after each transmit before re-arbitration (0 = none).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_req  in  NUM_REQ  per-requester level request for the send path
- i_commit  in  NUM_REQ  1-cycle pulse: buffer filled, send now
- i_abort  in  NUM_REQ  1-cycle pulse: release grant without sending
- i_dest_ip  in  NUM_REQ*32  per-requester destination IP; slice k = [32k+31:32k]
- i_src_port  in  NUM_REQ*16  per-requester source port
- i_dest_port  in  NUM_REQ*16  per-requester destination port
- i_length  in  NUM_REQ*16  per-requester payload length in bytes
- i_tx_done  in  1  1-cycle pulse from eth core: frame sent
- o_grant  out  NUM_REQ  one-hot registered grant; the external send-buffer write mux uses it
- o_send_dest_ip  out  32  to eth core
- o_send_src_port  out  16  to eth core
- o_send_dest_port  out  16  to eth core
- o_send_length  out  16  to eth core
- o_send_trigger  out  1  1-cycle start pulse to eth core
- o_done  out  NUM_REQ  1-cycle pulse: requester k's frame completed
- o_err  out  NUM_REQ  1-cycle pulse: requester k's commit rejected (bad length)
- o_timeout  out  NUM_REQ  1-cycle pulse: requester k's frame timed out
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst high at a clock edge):
  - State = IDLE; every output is 0; the round-robin pointer is 0; the timeout and gap counters are 0.
  - Reset asserted mid-operation aborts immediately; no trigger or completion pulse is emitted.
- States: IDLE, GRANT, TRIGGER, WAIT_DONE, GAP.
- IDLE:
  - If any i_req is high, grant the first requester at or after the pointer (wrapping modulo NUM_REQ). o_grant is asserted on the next cycle and the state goes to GRANT.
  - The pointer becomes k+1 mod NUM_REQ when requester k is granted.
- GRANT:
  - o_grant[k] is held.
  - Dropping i_req[k] has no effect; the requester must commit or abort.
  - i_commit and i_abort from non-granted requesters are ignored.
- i_abort[k] in GRANT: o_grant clears next cycle; state goes to IDLE. If i_commit[k] and i_abort[k] are sampled in the same cycle, abort wins.
- i_commit[k] sampled at cycle t:
  - If i_length slice is 0 or greater than BUF_BYTES: o_err[k] pulses at t+1, grant clears, state goes to IDLE. No trigger, header registers unchanged.
  - Otherwise, at t+1: the header outputs are loaded from slice k, o_grant is 0, o_send_trigger is 1 (for exactly one cycle), and state is TRIGGER. State is WAIT_DONE at t+2.
- Header outputs hold their values until the next valid commit.
- WAIT_DONE:
  - The timeout counter increments each cycle.
  - If i_tx_done is sampled at cycle u, o_done[k] pulses at u+1 and the state goes to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done, o_timeout[k] pulses and the state goes to GAP.
  - If done and timeout occur in the same cycle, done wins and no timeout pulse is emitted.
  - i_tx_done in any other state is ignored.
- GAP: stays for exactly GAP_CYCLES cycles, then goes to IDLE. If GAP_CYCLES = 0, the transition goes directly to IDLE.
- Counters are sized with $clog2 of their limits; the timeout counter clears on entry to WAIT_DONE and the gap counter clears on entry to GAP.
- Requests arriving during TRIGGER, WAIT_DONE or GAP wait; they are arbitrated on return to IDLE.

Test Plan:
- Single request: i_req[0]=1, commit with length 64, dest_ip 0x0A000002, ports 1234/5678 → o_grant=01 one cycle later; trigger for 1 cycle at commit+1 with those header values; i_tx_done 10 cycles later → o_done[0] pulse; o_busy low after GAP=16 cycles.
- Round-robin: i_req=11 held, each grant committed and completed → grant order 0,1,0,1; pointer wraps.
- Bad length: commit with length 0 → o_err[k]; commit with length 129 (BUF_SIZE=1024) → o_err[k]; neither produces a trigger, and the headers are unchanged.
- Abort and races: i_commit and i_abort on the same cycle → IDLE, no trigger; commit from a non-granted requester → ignored.
- Timeout: TIMEOUT_CYCLES=100, no i_tx_done → o_timeout[k] 100 cycles after WAIT_DONE entry; done coinciding with the last count → o_done[k] only.
- Reset mid-WAIT_DONE: assert i_rst → next cycle state IDLE, all outputs 0, no o_done, pointer 0.
